// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result bundle for nibble_serial_subtractor.
// Optional feature macro: NSS_ADD_MODE_EN adds the 'op' select line
// (0 = subtract, 1 = add), driven by the master alongside the operands.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             bout;
  logic             neg;
  logic             zero;
  logic             ovf;

`ifdef NSS_ADD_MODE_EN
  logic             op;

  modport master (
    output start, a, b, bin, op,
    input  busy, done, out, bout, neg, zero, ovf
  );

  modport slave (
    input  start, a, b, bin, op,
    output busy, done, out, bout, neg, zero, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, out, bout, neg, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, out, bout, neg, zero, ovf
  );
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: out = a - b - bin, one nibble per clock,
// LSB nibble first, through a 4-bit carry-lookahead slice. A registered
// borrow links successive nibbles. Results and flags hold until the next
// completed operation or reset.
// Optional feature macro: NSS_ADD_MODE_EN (adds op input; op=1 computes
// a + b + bin and bout reports the carry-out).
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  nibble_serial_subtractor_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Inter-nibble link: a borrow when subtracting, a carry when adding.
  logic             link_q, link_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             bout_q, bout_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             add_mode;

`ifdef NSS_ADD_MODE_EN
  logic             op_q, op_d;
  assign add_mode = op_q;
`else
  assign add_mode = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // 4-bit carry-lookahead slice. Subtraction feeds ~b and ~borrow so that
  // the same adder yields a - b - borrow; the carry-out is then ~borrow.
  // ---------------------------------------------------------------------
  logic [3:0] x_nib;
  logic [3:0] y_nib;
  logic       cin;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic       cout;
  logic [3:0] sum;

  assign x_nib = a_sh_q[3:0];
  assign y_nib = add_mode ? b_sh_q[3:0] : ~b_sh_q[3:0];
  assign cin   = add_mode ? link_q : ~link_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gp
      assign g[gi]   = x_nib[gi] & y_nib[gi];
      assign p[gi]   = x_nib[gi] ^ y_nib[gi];
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Lookahead carries, each flattened to two levels of logic.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  // Partial result with the new nibble entering at the top; after NIB
  // shifts the LSB nibble has reached bit 0.
  logic [WIDTH-1:0] res_shift;
  logic             link_next;
  logic             last_nib;

  assign res_shift = (res_q >> 4) | (WIDTH'(sum) << (WIDTH - 4));
  assign link_next = add_mode ? cout : ~cout;
  assign last_nib  = (cnt_q == CW'(NIB - 1));

  // Next-state and datapath update: accept in IDLE/DONE, one nibble per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    link_d  = link_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    out_d   = out_q;
    bout_d  = bout_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`ifdef NSS_ADD_MODE_EN
    op_d    = op_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          link_d  = bus.bin;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
`ifdef NSS_ADD_MODE_EN
          op_d    = bus.op;
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        res_d  = res_shift;
        link_d = link_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_nib) begin
          // Only the final result ever reaches the output registers.
          out_d  = res_shift;
          bout_d = link_next;
          neg_d  = res_shift[WIDTH-1];
          zero_d = (res_shift == '0);
          if (add_mode) begin
            ovf_d = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          end else begin
            ovf_d = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          end
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      link_q  <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      out_q   <= '0;
      bout_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef NSS_ADD_MODE_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      link_q  <= link_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`ifdef NSS_ADD_MODE_EN
      op_q    <= op_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;
  assign bus.bout = bout_q;
  assign bus.neg  = neg_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing out = a - b - bin, one 4-bit nibble per clock, LSB nibble first.
- Each nibble is computed as a + ~b + ~borrow on a 4-bit carry-lookahead slice; a registered borrow links successive nibbles.
- Inverse-direction companion to the team's 4-bit lookahead adder; used in the datapath wherever a wide difference is needed without a full-width combinational chain.
- Start/busy/done handshake; results and status flags are held until the next operation.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived (localparam): number of nibble cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new operation; sampled only when busy=0
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result valid
- out  output  WIDTH  difference
- bout  output  1  borrow-out, unsigned a < b + bin
- neg  output  1  out[WIDTH-1]
- zero  output  1  out == 0
- ovf  output  1  two's-complement overflow of the subtraction

Behaviour:
- Reset: on any rising edge with rst_n=0, the block enters IDLE.
  - busy, done, out, bout, neg, zero and ovf all go to 0.
  - Internal operand and borrow registers are cleared.
  - This applies equally during an operation in progress: the operation is abandoned and no done pulse is issued.
- FSM states:
  - IDLE: busy=0. An edge with start=1 latches a, b, bin into internal shift registers, clears the nibble counter and moves to RUN.
  - RUN: busy=1. Each edge processes the next nibble.
    - Nibble sum = a_nib + ~b_nib + ~borrow_reg.
    - The sum is shifted into the partial-result register.
    - borrow_reg becomes the inverse of the slice carry-out.
    - The counter increments. On the NIB-th processed nibble, move to DONE.
  - DONE: lasts one cycle, done=1, busy=0, then return to IDLE.
    - out, bout, neg, zero and ovf are loaded on the edge that enters DONE.
    - An edge in DONE with start=1 behaves exactly like an edge in IDLE with start=1 (back-to-back operation allowed).
- Latency: start is sampled at edge k. done=1 during the cycle following edge k+NIB. The next operation can be accepted at edge k+NIB+1.
- start while busy=1 is ignored: no latch, no effect on the result in progress.
- a, b and bin may change freely after the start edge.
- Output hold:
  - out and the flags keep the previous result throughout RUN and afterwards.
  - They change only on entry to DONE or on reset. Partial results are never visible on out.
- Flag definitions:
  - ovf = (a[W-1] != b[W-1]) && (out[W-1] != a[W-1]), using the latched a and b.
  - bout = borrow_reg after the last nibble.
  - zero and neg are derived from the final out.
- bin=1 with a == b gives out = all ones, bout=1.

Optional Feature:
- Macro: NSS_ADD_MODE_EN.
- When defined:
  - An extra input port op (1 bit) is added and latched with the operands at start. op=0 selects subtract; op=1 selects add.
  - In add mode the slice computes a + b + bin directly, with no inversion. bout then reports carry-out.
  - In add mode, ovf = (a[W-1] == b[W-1]) && (out[W-1] != a[W-1]).
- When undefined: the op port does not exist and the block always subtracts.

Test Plan (WIDTH=16, NIB=4):
- a=0x1234, b=0x0234, bin=0, start pulse at edge k -> done high in the cycle after edge k+4; out=0x1000, bout=0, neg=0, zero=0, ovf=0; busy high for exactly 4 cycles.
- a=0x0000, b=0x0001, bin=0 -> out=0xFFFF, bout=1, neg=1, zero=0, ovf=0.
- a=0x8000, b=0x0001 -> out=0x7FFF, bout=0, neg=0, ovf=1. Separately, a=0x7FFF, b=0xFFFF -> out=0x8000, ovf=1, bout=1.
- a=0x5555, b=0x5555, bin=0 -> out=0x0000, zero=1. Repeat with bin=1 -> out=0xFFFF, bout=1, neg=1, zero=0.
- Start a=0x00F0, b=0x000F; pulse start again at edge k+2 with a=0xFFFF, b=0 -> second start ignored, result out=0x00E1. Then restart, drive rst_n=0 at edge k+2 -> busy=0 and out/flags=0 from that edge, no done pulse.
- With NSS_ADD_MODE_EN and op=1: a=0xFFFF, b=0x0001, bin=0 -> out=0x0000, bout=1, zero=1, ovf=0. Back-to-back start issued in the DONE cycle is accepted, and its done follows 4 cycles later.
